uart_tx_cfg: RTL and testbench

Parametrised UART transmitter, the next generation of the team's fixed 8N1 transmitter. Data width, parity mode, stop-bit count and tick oversampling are configurable at elaboration time. The block sits between a byte/word source (FIFO or control FSM) and the serial TX pin. It is paced by an external baud-tick generator that pulses at OVERSAMPLE x baud rate.

---
 rtl/uart_tx_cfg.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter.
// Frame = start bit, DATA_BITS payload bits (LSB first), optional parity bit,
// STOP_BITS stop bits. Each bit lasts OVERSAMPLE baud-tick pulses.
//
// Handshake: start_trigger is sampled on every clk edge while the FSM is IDLE;
// a high sample accepts data_in (there is no ready output, acceptance is
// visible as tx_busy rising on the next cycle). Requests while busy are dropped.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start_trigger,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 o_tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(OVERSAMPLE) + 1;
  localparam int IW = $clog2(DATA_BITS) + 1;

  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_SEL   = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Reject illegal configurations at elaboration time.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 1) begin : g_bad_oversample
    $error("uart_tx_cfg: OVERSAMPLE must be >= 1");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
    $error("uart_tx_cfg: PARITY_EN must be 0 or 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]           state_q,    state_d;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [IW-1:0]        idx_q,      idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 par_q,      par_d;
  logic                 tx_q,       tx_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 bit_end;

  // Next-state logic: tick counting, bit sequencing and registered line value.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    done_d     = 1'b0;
    bit_end    = tick && (tick_cnt_q == TICK_LAST);

    if (state_q != S_IDLE && tick) begin
      if (tick_cnt_q == TICK_LAST) tick_cnt_d = '0;
      else                         tick_cnt_d = tick_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_trigger) begin
          shift_d    = data_in;
          par_d      = (^data_in) ^ ODD_SEL;
          tick_cnt_d = '0;
          idx_d      = '0;
          stop_cnt_d = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // The shift register moves right so the current bit is always at [0].
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            stop_cnt_d = 1'b0;
            state_d    = S_IDLE;
            done_d     = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_tx    = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations share clk/rst.
//   u0: 8N1, OVERSAMPLE=4        u1: 8E1, OVERSAMPLE=4
//   u2: 8O1, OVERSAMPLE=4        u3: 7N2, OVERSAMPLE=4, tick every 3rd clk
module tb_uart_tx_cfg;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       tick_a;
  logic       tick_b;
  logic [3:0] start_w;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [3:0] tx_w, busy_w, done_w;

  int errors = 0;
  int checks = 0;
  int phase  = 0;

  uart_tx_cfg #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(4)) u0 (
    .clk(clk), .rst(rst), .tick(tick_a), .start_trigger(start_w[0]), .data_in(d0),
    .o_tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_cfg #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(4)) u1 (
    .clk(clk), .rst(rst), .tick(tick_a), .start_trigger(start_w[1]), .data_in(d1),
    .o_tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_cfg #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .OVERSAMPLE(4)) u2 (
    .clk(clk), .rst(rst), .tick(tick_a), .start_trigger(start_w[2]), .data_in(d2),
    .o_tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_cfg #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .OVERSAMPLE(4)) u3 (
    .clk(clk), .rst(rst), .tick(tick_b), .start_trigger(start_w[3]), .data_in(d3),
    .o_tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  // Advance one clock; inputs for the next edge are set 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    phase  = (phase + 1) % 3;
    tick_b = (phase == 0);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int sel, input string tag);
    chk({tag, "_tx"},   tx_w[sel],   1'b1);
    chk({tag, "_busy"}, busy_w[sel], 1'b0);
    chk({tag, "_done"}, done_w[sel], 1'b0);
  endtask

  // Driver: present a word and pulse start_trigger for one edge.
  task automatic send(input int sel, input logic [8:0] val);
    case (sel)
      0:       d0 = val[7:0];
      1:       d1 = val[7:0];
      2:       d2 = val[7:0];
      default: d3 = val[6:0];
    endcase
    start_w[sel] = 1'b1;
    step();
    start_w[sel] = 1'b0;
  endtask

  // Walk a frame bit by bit; exp[i] is the i-th bit on the line.
  // poke_at >= 0 raises start_trigger with all-ones data on that cycle.
  task automatic check_frame(input int sel, input string tag, input logic [15:0] exp,
                             input int nb, input int cyc, input int poke_at);
    int k;
    k = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < cyc; c++) begin
        chk($sformatf("%s_bit%0d_c%0d", tag, b, c), tx_w[sel], exp[b]);
        chk($sformatf("%s_busy%0d_c%0d", tag, b, c), busy_w[sel], 1'b1);
        chk($sformatf("%s_done%0d_c%0d", tag, b, c), done_w[sel], 1'b0);
        if (k == poke_at) begin
          d0 = 8'hFF;
          start_w[sel] = 1'b1;
        end
        step();
        start_w[sel] = 1'b0;
        k++;
      end
    end
    chk({tag, "_end_done"}, done_w[sel], 1'b1);
    chk({tag, "_end_busy"}, busy_w[sel], 1'b0);
    chk({tag, "_end_tx"},   tx_w[sel],   1'b1);
  endtask

  initial begin
    rst = 1'b1; tick_a = 1'b1; tick_b = 1'b0; start_w = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    step(); step(); step();
    for (int s = 0; s < 4; s++) chk_idle(s, $sformatf("reset_u%0d", s));
    rst = 1'b0;
    step();

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    send(0, 9'h0A5);
    check_frame(0, "t1", 16'h034A, 10, 4, -1);
    step();
    chk_idle(0, "t1_after");

    // Even / odd parity on 0xA5 (four ones)
    send(1, 9'h0A5);
    check_frame(1, "t2_even", 16'h054A, 11, 4, -1);
    step();
    send(2, 9'h0A5);
    check_frame(2, "t2_odd", 16'h074A, 11, 4, -1);
    step();
    chk_idle(2, "t2_after");

    // 7N2 0x41, tick every third clk; align acceptance with a tick edge
    for (int i = 0; i < 3 && !tick_b; i++) step();
    chk("t3_align", tick_b, 1'b1);
    send(3, 9'h041);
    check_frame(3, "t3", 16'h0382, 10, 12, -1);
    step();
    chk_idle(3, "t3_after");

    // Mid-frame request ignored; request in tx_done cycle starts at once
    send(0, 9'h0A5);
    check_frame(0, "t4a", 16'h034A, 10, 4, 14);
    send(0, 9'h03C);
    check_frame(0, "t4b", 16'h0278, 10, 4, -1);
    step();
    chk_idle(0, "t4_after");
    step();
    chk_idle(0, "t4_noqueue");

    // Reset during DATA bit 3
    send(0, 9'h0A5);
    repeat (17) step();
    chk("t5_bit3_tx", tx_w[0], 1'b0);
    chk("t5_bit3_busy", busy_w[0], 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle(0, "t5_reset");
    // Reset and request together: reset wins, request dropped
    rst = 1'b1; d0 = 8'h3C; start_w[0] = 1'b1;
    step();
    rst = 1'b0; start_w[0] = 1'b0;
    chk_idle(0, "t5_rst_start");
    step();
    chk_idle(0, "t5_dropped");
    send(0, 9'h03C);
    check_frame(0, "t5b", 16'h0278, 10, 4, -1);
    step();

    // Ticks stall for 100 clks during START
    tick_a = 1'b0;
    send(0, 9'h0A5);
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("t6_hold_tx%0d", i), tx_w[0], 1'b0);
      chk($sformatf("t6_hold_busy%0d", i), busy_w[0], 1'b1);
      step();
    end
    tick_a = 1'b1;
    check_frame(0, "t6", 16'h034A, 10, 4, -1);
    step();
    chk_idle(0, "t6_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
